// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data bundle used between pipeline stages.
//   master : drives valid and data, samples ready
//   slave  : samples valid and data, drives ready
// A beat transfers on a rising edge where valid and ready are both high.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 64
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with a valid/ready handshake. It carries an
// opaque WIDTH-bit payload from one core stage to the next. Downstream
// back-pressure causes a stall, and flush squashes every beat the stage holds.
//
// Ports
//   cpu_clk    in   clock, rising edge
//   cpu_rst    in   synchronous active-high reset
//   flush      in   synchronous squash of all held beats
//   up         slave  modport : up.valid/up.data in, up.ready out
//   dn         master modport : dn.valid/dn.data out, dn.ready in
//   occupancy  out  number of held beats (0..2, or 0..1 when SKID=0)
//
// SKID=1 drives up.ready from state only, so ready never ripples through the
// stage. When downstream stalls, the second register (skid) absorbs the beat
// that was already in flight.
// SKID=0 uses a single register. Its up.ready depends combinationally on dn.ready.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | nothing held, dn.valid=0, dn.data=BUBBLE
// HALF  | one beat in main, presented downstream
// FULL  | main presented downstream, skid holds the next beat (SKID=1)
module pipe_stage_buf #(
  parameter int             WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit             SKID   = 1'b1
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              flush,
  pipe_stage_buf_if.slave   up,
  pipe_stage_buf_if.master  dn,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       occ_q;

  logic up_ready_int;
  logic dn_valid_int;
  logic accept;
  logic emit;

  function automatic logic [1:0] occ_of(input state_t s);
    case (s)
      ST_HALF: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

  assign dn_valid_int = (state_q != ST_EMPTY);

  // SKID=1: ready is decoded from the state register only.
  // SKID=0: the single register can take a beat whenever its content leaves.
  // In both cases ready is held low while reset is asserted, so no beat
  // can appear to be taken during reset.
  generate
    if (SKID) begin : g_ready_skid
      assign up_ready_int = !cpu_rst && (state_q != ST_FULL);
    end else begin : g_ready_flow
      assign up_ready_int = !cpu_rst && (dn.ready || !dn_valid_int);
    end
  endgenerate

  assign accept = up.valid && up_ready_int;
  assign emit   = dn_valid_int && dn.ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_HALF;
          main_d  = up.data;
        end
      end

      ST_HALF: begin
        if (accept && emit) begin
          main_d = up.data;
        end else if (accept) begin
          // Acceptance without emission happens only with SKID=1, because
          // SKID=0 ready requires dn.ready while a beat is held.
          if (SKID) begin
            state_d = ST_FULL;
            skid_d  = up.data;
          end
        end else if (emit) begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      end

      ST_FULL: begin
        if (emit) begin
          state_d = ST_HALF;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end

      default: begin
        state_d = ST_EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase

    // A beat accepted in this cycle is dropped as well. A beat emitted in
    // this cycle has already been delivered, and the consumer squashes it.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      occ_q   <= occ_of(state_d);
    end
  end

  assign up.ready  = up_ready_int;
  assign dn.valid  = dn_valid_int;
  // main_q already holds BUBBLE when the stage is empty. The gate below also
  // guarantees that dn.data shows the NOP encoding whenever dn.valid is low.
  assign dn.data   = dn_valid_int ? main_q : BUBBLE;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
  localparam int         W   = 16;
  localparam logic [W-1:0] BUB = 16'h0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, flush1, rst0, flush0;
  logic [1:0] occ1, occ0;

  pipe_stage_buf_if #(.WIDTH(W)) up1 ();
  pipe_stage_buf_if #(.WIDTH(W)) dn1 ();
  pipe_stage_buf_if #(.WIDTH(W)) up0 ();
  pipe_stage_buf_if #(.WIDTH(W)) dn0 ();

  pipe_stage_buf #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b1)) u_skid (
    .cpu_clk   (clk),
    .cpu_rst   (rst1),
    .flush     (flush1),
    .up        (up1),
    .dn        (dn1),
    .occupancy (occ1)
  );

  pipe_stage_buf #(.WIDTH(W), .BUBBLE(BUB), .SKID(1'b0)) u_flow (
    .cpu_clk   (clk),
    .cpu_rst   (rst0),
    .flush     (flush0),
    .up        (up0),
    .dn        (dn0),
    .occupancy (occ0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic v, input logic [W-1:0] d, input logic [1:0] o);
    chk({tag, ".valid"}, {31'd0, dn1.valid}, {31'd0, v});
    chk({tag, ".data"},  {16'd0, dn1.data},  {16'd0, d});
    chk({tag, ".occ"},   {30'd0, occ1},      {30'd0, o});
  endtask

  task automatic chk0(input string tag, input logic v, input logic [W-1:0] d, input logic [1:0] o);
    chk({tag, ".valid"}, {31'd0, dn0.valid}, {31'd0, v});
    chk({tag, ".data"},  {16'd0, dn0.data},  {16'd0, d});
    chk({tag, ".occ"},   {30'd0, occ0},      {30'd0, o});
  endtask

  initial begin
    rst1 = 1'b1; flush1 = 1'b0; up1.valid = 1'b1; up1.data = 16'h00AA; dn1.ready = 1'b1;
    rst0 = 1'b1; flush0 = 1'b0; up0.valid = 1'b1; up0.data = 16'h00AA; dn0.ready = 1'b1;

    // 1: reset held for 3 cycles with a beat offered
    repeat (3) begin
      tick();
      chk("rst1.up_ready", {31'd0, up1.ready}, 32'd0);
      chk1("rst1", 1'b0, BUB, 2'd0);
      chk("rst0.up_ready", {31'd0, up0.ready}, 32'd0);
      chk0("rst0", 1'b0, BUB, 2'd0);
    end
    rst1 = 1'b0; up1.valid = 1'b0;
    rst0 = 1'b0; up0.valid = 1'b0;
    tick();
    chk1("post_rst1", 1'b0, BUB, 2'd0);
    chk0("post_rst0", 1'b0, BUB, 2'd0);

    // 2: streaming 1..8 through the skid stage
    dn1.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up1.valid = 1'b1; up1.data = W'(i);
      #1;
      chk("stream.up_ready", {31'd0, up1.ready}, 32'd1);
      tick();
      chk1("stream", 1'b1, W'(i), 2'd1);
    end
    up1.valid = 1'b0;
    tick();
    chk1("stream_drain", 1'b0, BUB, 2'd0);

    // 3: back-pressure fills both entries, then drains in order
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 16'h000A;
    tick();
    chk1("bp_a", 1'b1, 16'h000A, 2'd1);
    up1.data = 16'h000B;
    #1;
    chk("bp_b.up_ready", {31'd0, up1.ready}, 32'd1);
    tick();
    chk1("bp_full", 1'b1, 16'h000A, 2'd2);
    chk("bp_full.up_ready", {31'd0, up1.ready}, 32'd0);
    up1.data = 16'h000E;            // offered but must not be taken while full
    tick();
    chk1("bp_hold", 1'b1, 16'h000A, 2'd2);
    up1.valid = 1'b0; dn1.ready = 1'b1;
    tick();
    chk1("bp_drain1", 1'b1, 16'h000B, 2'd1);
    chk("bp_drain1.up_ready", {31'd0, up1.ready}, 32'd1);
    tick();
    chk1("bp_drain2", 1'b0, BUB, 2'd0);

    // 4: flush in FULL with a beat offered
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 16'h000A; tick();
    up1.data = 16'h000B; tick();
    chk1("fl_full", 1'b1, 16'h000A, 2'd2);
    flush1 = 1'b1; up1.data = 16'h000C;
    tick();
    flush1 = 1'b0; up1.valid = 1'b0; dn1.ready = 1'b1;
    chk1("fl_after", 1'b0, BUB, 2'd0);
    repeat (2) begin
      tick();
      chk1("fl_no_c", 1'b0, BUB, 2'd0);
    end
    // flush in HALF while a beat is actually accepted: that beat is dropped
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 16'h000D; tick();
    chk1("fl_half", 1'b1, 16'h000D, 2'd1);
    flush1 = 1'b1; up1.data = 16'h00E0;
    tick();
    flush1 = 1'b0; up1.valid = 1'b0; dn1.ready = 1'b1;
    chk1("fl_half_after", 1'b0, BUB, 2'd0);
    tick();
    chk1("fl_half_no_e", 1'b0, BUB, 2'd0);

    // 6: reset in the middle of operation while FULL
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 16'h000A; tick();
    up1.data = 16'h000B; tick();
    chk1("mr_full", 1'b1, 16'h000A, 2'd2);
    dn1.ready = 1'b1; up1.data = 16'h0077; rst1 = 1'b1;
    #1;
    chk("mr.up_ready", {31'd0, up1.ready}, 32'd0);
    tick();
    rst1 = 1'b0; up1.valid = 1'b0;
    chk1("mr_after", 1'b0, BUB, 2'd0);
    up1.valid = 1'b1; up1.data = 16'h0021; tick();
    chk1("mr_flow1", 1'b1, 16'h0021, 2'd1);
    up1.data = 16'h0022; tick();
    chk1("mr_flow2", 1'b1, 16'h0022, 2'd1);
    up1.valid = 1'b0; tick();
    chk1("mr_flow_end", 1'b0, BUB, 2'd0);

    // 5: single-register stage with combinational ready
    dn0.ready = 1'b0;
    up0.valid = 1'b1; up0.data = 16'h0005;
    #1;
    chk("s0_empty.up_ready", {31'd0, up0.ready}, 32'd1);
    tick();
    chk0("s0_hold5", 1'b1, 16'h0005, 2'd1);
    up0.data = 16'h0009;
    #1;
    chk("s0_stall.up_ready", {31'd0, up0.ready}, 32'd0);
    tick();
    chk0("s0_stall", 1'b1, 16'h0005, 2'd1);
    up0.data = 16'h0006; dn0.ready = 1'b1;
    #1;
    chk("s0_flow.up_ready", {31'd0, up0.ready}, 32'd1);
    tick();
    chk0("s0_reload6", 1'b1, 16'h0006, 2'd1);
    up0.valid = 1'b0;
    tick();
    chk0("s0_drain", 1'b0, BUB, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
